divider_arbiter: RTL

Round-robin scheduler that shares one sequential divider core between two requesters (e.g. switch-driven front panel and a test/pattern source). It captures the winning requester's operands, starts the core, waits for completion under a watchdog, and returns quotient/remainder through a per-requester valid/ready response. Divide-by-zero is trapped locally and never reaches the core.

---
 rtl/divider_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one sequential divider core between two
// requesters, trapping divide-by-zero locally and guarding the core with a watchdog.
module divider_arbiter #(
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         resetp,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] dvnd0,
  input  logic [W-1:0] dvnd1,
  input  logic [W-1:0] dvsr0,
  input  logic [W-1:0] dvsr1,
  output logic         ack0,
  output logic         ack1,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  input  logic         rsp_ready0,
  input  logic         rsp_ready1,
  output logic [W-1:0] rsp_quotient,
  output logic [W-1:0] rsp_remainder,
  output logic         rsp_err,
  output logic         core_go,
  output logic [W-1:0] core_dividend,
  output logic [W-1:0] core_divisor,
  input  logic         core_done,
  input  logic [W-1:0] core_quotient,
  input  logic [W-1:0] core_remainder
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_reg, state_next;
  logic           owner_reg, owner_next;
  logic           last_reg, last_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           ack0_reg, ack0_next, ack1_reg, ack1_next;
  logic           valid0_reg, valid0_next, valid1_reg, valid1_next;
  logic           err_reg, err_next;
  logic           go_reg, go_next;
  logic [W-1:0]   quo_reg, quo_next, rem_reg, rem_next;
  logic [W-1:0]   dvnd_reg, dvnd_next, dvsr_reg, dvsr_next;

  logic           grant;
  logic [W-1:0]   sel_dvnd, sel_dvsr;

  // With both requesting, the one that was not served last wins.
  assign grant    = (req0 && req1) ? !last_reg : req1;
  assign sel_dvnd = grant ? dvnd1 : dvnd0;
  assign sel_dvsr = grant ? dvsr1 : dvsr0;

  always_ff @(posedge clk) begin
    if (resetp) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;
      cnt_reg    <= '0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      valid0_reg <= 1'b0;
      valid1_reg <= 1'b0;
      err_reg    <= 1'b0;
      go_reg     <= 1'b0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvnd_reg   <= '0;
      dvsr_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
      ack0_reg   <= ack0_next;
      ack1_reg   <= ack1_next;
      valid0_reg <= valid0_next;
      valid1_reg <= valid1_next;
      err_reg    <= err_next;
      go_reg     <= go_next;
      quo_reg    <= quo_next;
      rem_reg    <= rem_next;
      dvnd_reg   <= dvnd_next;
      dvsr_reg   <= dvsr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    go_next     = 1'b0;
    valid0_next = valid0_reg;
    valid1_next = valid1_reg;
    err_next    = err_reg;
    quo_next    = quo_reg;
    rem_next    = rem_reg;
    dvnd_next   = dvnd_reg;
    dvsr_next   = dvsr_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          owner_next = grant;
          ack0_next  = !grant;
          ack1_next  = grant;
          if (sel_dvsr == '0) begin
            // Zero divisor never reaches the core; answer immediately.
            state_next  = RESP;
            err_next    = 1'b1;
            quo_next    = '1;
            rem_next    = sel_dvnd;
            valid0_next = !grant;
            valid1_next = grant;
          end else begin
            state_next = ISSUE;
            dvnd_next  = sel_dvnd;
            dvsr_next  = sel_dvsr;
            go_next    = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          quo_next    = core_quotient;
          rem_next    = core_remainder;
          err_next    = 1'b0;
          valid0_next = !owner_reg;
          valid1_next = owner_reg;
          state_next  = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          quo_next    = '0;
          rem_next    = '0;
          err_next    = 1'b1;
          valid0_next = !owner_reg;
          valid1_next = owner_reg;
          state_next  = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        valid0_next = !owner_reg;
        valid1_next = owner_reg;
        if (owner_reg ? rsp_ready1 : rsp_ready0) begin
          last_next   = owner_reg;
          valid0_next = 1'b0;
          valid1_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ack0          = ack0_reg;
  assign ack1          = ack1_reg;
  assign rsp_valid0    = valid0_reg;
  assign rsp_valid1    = valid1_reg;
  assign rsp_quotient  = quo_reg;
  assign rsp_remainder = rem_reg;
  assign rsp_err       = err_reg;
  assign core_go       = go_reg;
  assign core_dividend = dvnd_reg;
  assign core_divisor  = dvsr_reg;

endmodule
